single_log2_iter: RTL and testbench
===================================

Name: single_log2_iter

Overview:
- Iterative single-precision base-2 logarithm: c = log2(a), IEEE-754 binary32 in and out.
- Inverse companion of the power-of-two block in the single-precision library. Feeds exponent/log stages of the Precision/Single datapaths.
- One result per operation. Fractional bits are produced serially by repeated mantissa squaring, so area is small and latency is fixed.

Parameters:
- FRAC_BITS, 23, number of fractional log bits computed. Legal range 8..23. Also sets the iteration count.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- in_valid  input  1  operand a valid
- in_ready  output  1  block idle and able to accept
- a  input  32  binary32 operand
- out_valid  output  1  one-cycle pulse, c valid
- c  output  32  binary32 result log2(a)

Behaviour:
- Reset: rstn and clk are decided as stated above (synchronous, active-low). While rstn=0 at a clk edge: state IDLE, out_valid=0, c=0, iteration counter=0. in_ready=0 while rstn=0.
- Reset mid-operation aborts the operation; the in-flight operand is discarded and produces no out_valid.
- States: IDLE, ITER, NORM.
- in_ready = (state==IDLE) & rstn.
- Accept on an edge with in_valid & in_ready. in_valid while busy is ignored; no queueing.
- Accept edge T0 captures:
  - E = a[30:23]-127, as a 9-bit signed value.
  - m = {1,a[22:0]}, 24-bit unsigned, format 1.23.
  - A special-case code from a.
  - Counter = 0.
  - State goes to ITER.
- ITER, one squaring per edge, T1..T_FRAC_BITS:
  - p = m*m, 48-bit.
  - If p[47]=1: fraction bit = 1, m = p[47:24].
  - Else: fraction bit = 0, m = p[46:23].
  - Truncation, no rounding.
  - Fraction bits shift in MSB-first. After FRAC_BITS edges, go to NORM.
- NORM, edge T_(FRAC_BITS+1):
  - V = E*2^FRAC_BITS + frac, signed fixed point.
  - If V=0: c=0x00000000.
  - Else: s = sign(V); M = |V|; k = index of the leading 1 of M.
  - Exponent field = 127 + k - FRAC_BITS.
  - Mantissa = the bits of M below k, left-aligned into 23 bits, zero-filled, truncated.
  - c = {s, exponent field, mantissa}.
  - out_valid=1; state goes to IDLE.
- Next edge: out_valid=0. c holds its value until the next NORM.
- Latency: out_valid is high in the cycle after edge T_(FRAC_BITS+1), i.e. FRAC_BITS+1 edges after acceptance.
- in_ready is high in that same cycle, so back-to-back operations are possible. Throughput is one result per FRAC_BITS+1 cycles.
- Special cases still traverse ITER/NORM so latency is constant. The special code overrides c at NORM:
  - Exponent field 0 (zero or denormal), either sign: c=0xFF800000 (-inf).
  - a[31]=1 and a is nonzero, non-NaN: c=0x7FC00000 (NaN).
  - a = +inf (0x7F800000): c=0x7F800000.
  - NaN input: c=0x7FC00000.
- Widths:
  - V needs 9+FRAC_BITS bits.
  - k ranges 0..FRAC_BITS+7.
  - The exponent field always stays in 1..133, so no overflow or underflow handling is needed.

Test Plan:
- Reset, then single ops:
  - a=0x3F800000 (1.0) -> c=0x00000000.
  - a=0x41000000 (8.0) -> c=0x40400000.
  - a=0x3F000000 (0.5) -> c=0xBF800000.
  - For each, out_valid pulses exactly 1 cycle, FRAC_BITS+1 edges after acceptance (24 at default).
- Extremes:
  - a=0x00800000 -> c=0xC2FC0000 (-126).
  - a=0x7F7FFFFF -> c=0x42FF...; exact value from the bit-accurate squaring model, compared bit-exact.
- Fractional: a=0x40400000 (3.0) -> c bit-exact against the squaring/truncation reference model and within 2 ulp of 0x3FCAE00D.
- Specials, each with unchanged latency:
  - a=0x00000000 -> 0xFF800000.
  - a=0x80000000 -> 0xFF800000.
  - a=0xBF800000 -> 0x7FC00000.
  - a=0x7F800000 -> 0x7F800000.
  - a=0x7FC00001 -> 0x7FC00000.
- Handshake:
  - Hold in_valid high with a stream of operands: in_ready is low during ITER/NORM, and busy-cycle operands are not consumed.
  - Back-to-back acceptance occurs in the out_valid cycle.
  - Result count equals accept count.
- Reset mid-operation: deassert rstn at ITER cycle 10 for 1 cycle. Then out_valid=0, c=0, and in_ready=1 after release. No stale result appears. The next op (a=0x41000000) returns 0x40400000.

Source files
------------

// File: rtl/single_log2_iter.sv
// rtl/single_log2_iter.sv - iterative binary32 log2 using serial mantissa squaring
module single_log2_iter #(
    parameter int FRAC_BITS = 23
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    output logic [31:0] c
);

    localparam int VW = 9 + FRAC_BITS;
    localparam int KW = 5;
    localparam int CW = 5;

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NINF = 2'd1;
    localparam logic [1:0] SP_NAN  = 2'd2;
    localparam logic [1:0] SP_PINF = 2'd3;

    typedef enum logic [1:0] {IDLE, ITER, NORM} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [8:0]             e_reg;
    logic [23:0]            m_reg;
    logic [FRAC_BITS-1:0]   frac_reg;
    logic [1:0]             spec_reg;
    logic [1:0]             spec_in;
    logic [47:0]            sq;
    logic [VW-1:0]          v_bits;
    logic [VW-1:0]          mag;
    logic [KW-1:0]          k;
    logic [KW-1:0]          sh;
    logic [VW+22:0]         wide_sh;
    logic [7:0]             exp_f;
    logic [31:0]            norm_c;
    logic [31:0]            res;
    logic                   unused_bits;

    assign in_ready = (state == IDLE) & rstn;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = ITER;
            ITER: if (cnt == CW'(FRAC_BITS - 1)) state_nxt = NORM;
            NORM: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Special operands still run the full iteration so latency never varies.
    always_comb begin
        spec_in = SP_NONE;
        if (a[30:23] == 8'd0)
            spec_in = SP_NINF;
        else if (a[30:23] == 8'hFF) begin
            if (a[22:0] != 23'd0 || a[31]) spec_in = SP_NAN;
            else                           spec_in = SP_PINF;
        end else if (a[31])
            spec_in = SP_NAN;
    end

    assign sq = {24'd0, m_reg} * {24'd0, m_reg};

    // {E, frac} is already E*2^FRAC_BITS + frac because frac is non-negative.
    assign v_bits = {e_reg, frac_reg};
    assign mag    = v_bits[VW-1] ? (~v_bits + 1'b1) : v_bits;

    always_comb begin
        k = '0;
        for (int i = 0; i < VW; i++)
            if (mag[i]) k = KW'(i);
    end

    assign sh      = KW'(VW - 1) - k;
    assign wide_sh = {mag, 23'd0} << sh;
    assign exp_f   = 8'(127 - FRAC_BITS) + {3'd0, k};
    assign norm_c  = (mag == '0) ? 32'd0 : {v_bits[VW-1], exp_f, wide_sh[VW+21 -: 23]};

    always_comb begin
        case (spec_reg)
            SP_NINF: res = 32'hFF80_0000;
            SP_NAN:  res = 32'h7FC0_0000;
            SP_PINF: res = 32'h7F80_0000;
            default: res = norm_c;
        endcase
    end

    assign unused_bits = ^{sq[22:0], wide_sh[VW+22], wide_sh[VW-2:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            c         <= 32'd0;
            e_reg     <= '0;
            m_reg     <= '0;
            frac_reg  <= '0;
            spec_reg  <= SP_NONE;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        e_reg    <= {1'b0, a[30:23]} - 9'd127;
                        m_reg    <= {1'b1, a[22:0]};
                        spec_reg <= spec_in;
                        frac_reg <= '0;
                        cnt      <= '0;
                    end
                end
                ITER: begin
                    cnt      <= cnt + 1'b1;
                    frac_reg <= {frac_reg[FRAC_BITS-2:0], sq[47]};
                    m_reg    <= sq[47] ? sq[47:24] : sq[46:23];
                end
                NORM: begin
                    c         <= res;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_single_log2_iter.sv
// tb/tb_single_log2_iter.sv - scoreboard bench for single_log2_iter
module tb_single_log2_iter;

    localparam int FB = 23;
    localparam int NV = 11;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic        out_valid;
    logic [31:0] c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepts = 0;
    int results = 0;
    int b2b = 0;
    bit acc_flag = 1'b0;
    bit prev_ov = 1'b0;
    logic [31:0] last_c = 32'd0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] tbl_a[NV];
    logic [31:0] tbl_c[NV];
    logic [31:0] stream_a[4];

    always #5 clk = ~clk;

    single_log2_iter #(.FRAC_BITS(FB)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .out_valid(out_valid), .c(c)
    );

    function automatic logic [31:0] ref_log2(input logic [31:0] x);
        longint e, m, p, fr, v, mag, mant;
        int k;
        logic s;
        e = x[30:23];
        e = e - 127;
        m = 64'h80_0000 | x[22:0];
        fr = 0;
        for (int i = 0; i < FB; i++) begin
            p = m * m;
            if (p[47]) begin fr = fr * 2 + 1; m = p >> 24; end
            else       begin fr = fr * 2;     m = p >> 23; end
        end
        v = e * (longint'(1) << FB) + fr;
        if (v == 0) return 32'd0;
        s = (v < 0);
        mag = s ? -v : v;
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        if (k >= 23) mant = (mag >> (k - 23)) & 64'h7F_FFFF;
        else         mant = (mag << (23 - k)) & 64'h7F_FFFF;
        return {s, 8'(127 + k - FB), mant[22:0]};
    endfunction

    function automatic logic [31:0] lookup(input logic [31:0] x);
        for (int i = 0; i < NV; i++)
            if (tbl_a[i] == x) return tbl_c[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (rstn && in_valid && in_ready) begin
            exp_q.push_back(lookup(a));
            acc_q.push_back(cyc);
            accepts++;
            if (out_valid) b2b++;
            acc_flag = 1'b1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", c);
            end else begin
                logic [31:0] e;
                int t;
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                check("result", c, e);
                check("latency", 32'((cyc - 1) - t), 32'(FB + 1));
                check("single_pulse", {31'd0, prev_ov}, 32'd0);
                check("ready_on_valid", {31'd0, in_ready}, 32'd1);
                results++;
                last_c = c;
            end
        end else if (exp_q.size() > 0 && in_ready && rstn) begin
            checks++;
            errors++;
            $display("FAIL ready_while_busy actual=1 required=0");
        end
        prev_ov = out_valid;
    end

    task automatic do_op(input logic [31:0] av);
        int n;
        n = 0;
        acc_flag = 1'b0;
        a = av;
        in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!acc_flag && n < 100);
        in_valid = 1'b0;
        if (!acc_flag) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL result_timeout actual=pending required=done");
        end
        @(negedge clk);
    endtask

    initial begin
        int acc0, b0, r0, d;

        tbl_a[0]  = 32'h3F80_0000; tbl_c[0]  = 32'h0000_0000;
        tbl_a[1]  = 32'h4100_0000; tbl_c[1]  = 32'h4040_0000;
        tbl_a[2]  = 32'h3F00_0000; tbl_c[2]  = 32'hBF80_0000;
        tbl_a[3]  = 32'h0080_0000; tbl_c[3]  = 32'hC2FC_0000;
        tbl_a[4]  = 32'h7F7F_FFFF; tbl_c[4]  = ref_log2(32'h7F7F_FFFF);
        tbl_a[5]  = 32'h4040_0000; tbl_c[5]  = ref_log2(32'h4040_0000);
        tbl_a[6]  = 32'h0000_0000; tbl_c[6]  = 32'hFF80_0000;
        tbl_a[7]  = 32'h8000_0000; tbl_c[7]  = 32'hFF80_0000;
        tbl_a[8]  = 32'hBF80_0000; tbl_c[8]  = 32'h7FC0_0000;
        tbl_a[9]  = 32'h7F80_0000; tbl_c[9]  = 32'h7F80_0000;
        tbl_a[10] = 32'h7FC0_0001; tbl_c[10] = 32'h7FC0_0000;
        stream_a[0] = 32'h4100_0000;
        stream_a[1] = 32'h3F00_0000;
        stream_a[2] = 32'h3F80_0000;
        stream_a[3] = 32'h0000_0000;

        repeat (3) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_c", c, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            do_op(tbl_a[i]);
            if (tbl_a[i] == 32'h7F7F_FFFF)
                check("max_top_bits", {16'd0, last_c[31:16]}, 32'h0000_42FF);
            if (tbl_a[i] == 32'h4040_0000) begin
                d = int'(last_c) - int'(32'h3FCA_E00D);
                if (d < 0) d = -d;
                checks++;
                if (d > 2) begin
                    errors++;
                    $display("FAIL log2_3_ulp actual=%h required=3fcae00d+-2", last_c);
                end
            end
        end

        acc0 = accepts;
        b0 = b2b;
        in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a = stream_a[i % 4];
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("stream_accepts", 32'(accepts - acc0), 32'd4);
        check("stream_back_to_back", 32'(b2b - b0), 32'd3);

        acc_flag = 1'b0;
        a = 32'h3F00_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_accepted", {31'd0, acc_flag}, 32'd1);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_c", c, 32'd0);
        check("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        acc_q.delete();
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_high", {31'd0, in_ready}, 32'd1);
        r0 = results;
        repeat (40) @(negedge clk);
        check("midrst_no_stale", 32'(results - r0), 32'd0);
        do_op(32'h4100_0000);
        check("post_reset_result", last_c, 32'h4040_0000);

        check("result_count", 32'(results), 32'(accepts - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
